uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range is 2 or greater.
REQ-002 Parameter PARITY, default 0, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits; legal values are 1 and 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
REQ-006 txena  input  1  one-cycle transmit request; txdata is valid in the same cycle.
REQ-007 txdata  input  8  byte to transmit.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 txbusy  output  1  high while a frame is in progress.
REQ-010 tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PAR and STOP, encoded in natural binary; an unused encoding SHALL return to IDLE on the next edge.
REQ-012 In IDLE, txena=1 SHALL be accepted on that edge, with these same-edge updates:
- txdata latched into an internal shift register;
- tx driven 0;
- txbusy set to 1;
- baud counter cleared;
- state set to START.
REQ-013 txbusy SHALL be 1 in the first cycle after acceptance, so a controller polling txbusy two cycles later always sees it high.
REQ-014 txena asserted while txbusy=1 SHALL be ignored, with no effect on the shift register, tx or the frame.
REQ-015 txdata SHALL be sampled only on the accepting edge; later changes SHALL not affect the frame.
REQ-016 The baud counter SHALL count 0 to CLKS_PER_BIT-1 and wrap to 0, and each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles.
REQ-017 START SHALL hold tx=0 for one bit time, then go to DATA.
REQ-018 DATA SHALL send bits 0 to 7, LSB first, and a 3-bit index SHALL count bits; after bit 7 the FSM goes to PAR if PARITY is nonzero, else to STOP.
REQ-019 The PAR bit value SHALL be:
- XOR of the 8 data bits for even parity;
- inverse of that XOR for odd parity.
REQ-020 STOP SHALL hold tx=1 for STOP_BITS bit times.
REQ-021 The frame length SHALL be F = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles; txbusy SHALL be 1 for exactly F cycles.
REQ-022 At the end of the last stop bit, on a single edge:
- state returns to IDLE;
- txbusy goes 0;
- tx_done is 1 for exactly that following cycle.
REQ-023 A txena present in the cycle where tx_done=1 SHALL be accepted (back-to-back frames), with no idle gap beyond the stop bits.
REQ-024 tx SHALL be driven from a register, so it is glitch-free.
REQ-025 Outside a frame, tx SHALL be 1.

Reset
REQ-026 With rst=0 at a rising edge, the block SHALL go to IDLE with tx=1, txbusy=0 and tx_done=0, and clear the baud counter, bit index and shift register.
REQ-027 Reset mid-frame SHALL abandon the frame immediately: tx=1 on the next cycle, no tx_done pulse.
REQ-028 Reset SHALL dominate txena in the same cycle.
REQ-029 Power-up state SHALL match the reset state.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; txena pulse with txdata=0xA5 -> per 4-cycle bit tx=0,1,0,1,0,0,1,0,1,1; txbusy high for 40 cycles; tx_done one pulse in cycle 41.
REQ-031 PARITY=1, byte 0xA5 -> parity bit 0, 44-cycle frame; PARITY=2 -> parity bit 1.
REQ-032 STOP_BITS=2, byte 0x00 -> tx low for 36 cycles, then high for 8 cycles; txbusy high for 44 cycles.
REQ-033 txena with 0x3C pulsed mid-frame of 0xA5 -> 0xA5 frame unchanged, no second frame; txena with 0x3C in the tx_done cycle -> 0x3C start bit begins the next cycle.
REQ-034 rst=0 during bit 3 of the DATA state -> next cycle tx=1, txbusy=0, no tx_done; a subsequent txena transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ==== uart_tx_serializer : 8-bit UART transmitter, LSB first, optional parity, 1/2 stop bits ==
// ==== Rev 1.0 ===============================================================================
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txena,
  input  logic [7:0] txdata,
  output logic       tx,
  output logic       txbusy,
  output logic       tx_done
);

  localparam int            c_cw        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_bit_last = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  localparam logic          c_par_en    = (PARITY != 0);
  localparam logic          c_stop_last = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_stop_idx;
  logic            r_tx_n;
  logic            r_busy;
  logic            r_done;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == c_bit_last);

  // Line level is held inverted so an all-zero power-up state is already the idle state (tx=1).
  assign tx      = ~r_tx_n;
  assign txbusy  = r_busy;
  assign tx_done = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx_n     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + c_cnt_one;
      end
      case (r_state)
        S_IDLE: begin
          r_tx_n <= 1'b0;
          r_busy <= 1'b0;
          if (txena) begin
            r_shift    <= txdata;
            r_par      <= (PARITY == 2) ? ~(^txdata) : ^txdata;
            r_tx_n     <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx_n  <= ~r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd7) begin
              if (c_par_en) begin
                r_tx_n  <= ~r_par;
                r_state <= S_PAR;
              end else begin
                r_tx_n  <= 1'b0;
                r_state <= S_STOP;
              end
            end else begin
              r_tx_n  <= ~r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
        S_PAR: begin
          if (w_bit_end) begin
            r_tx_n  <= 1'b0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_idx == c_stop_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx_n  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ==== tb_uart_tx_serializer : scoreboard bench over four parity/stop configurations ====
// ==== Rev 1.0 ==========================================================================
module tb_uart_tx_serializer;

  localparam int N = 4;

  typedef struct {
    logic [7:0] data;
    logic       even;
    int         start;
    bit         abort;
    int         abort_len;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] txena = 4'h0;
  logic [7:0] txdata = 8'h00;
  logic [3:0] tx_w, busy_w, done_w;

  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  item_t fifo[4][32];
  int    wr[4] = '{0, 0, 0, 0};
  int    rd[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.CLKS_PER_BIT(N), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .txena(txena[0]), .txdata(txdata),
    .tx(tx_w[0]), .txbusy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(N), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .txena(txena[1]), .txdata(txdata),
    .tx(tx_w[1]), .txbusy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(N), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .txena(txena[2]), .txdata(txdata),
    .tx(tx_w[2]), .txbusy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(N), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .txena(txena[3]), .txdata(txdata),
    .tx(tx_w[3]), .txbusy(busy_w[3]), .tx_done(done_w[3]));

  function automatic int par_of(input int id);
    return (id == 1) ? 1 : (id == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int id);
    return (id == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int id, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, required %0d (cycle %0d)", name, id, act, req, cyc);
    end
  endtask

  // Monitor: records the line while txbusy is high and checks the frame when it drops.
  task automatic mon(input int id);
    logic  wave[64];
    int    len = 0;
    int    t0 = 0;
    bit    inf = 0;
    int    nbits, flen, bi, bad;
    logic  eb;
    item_t it;
    forever begin
      @(negedge clk);
      if (busy_w[id]) begin
        if (!inf) begin
          inf = 1;
          len = 0;
          t0  = cyc;
        end
        if (len < 64) wave[len] = tx_w[id];
        len++;
      end else if (inf) begin
        inf = 0;
        if (rd[id] == wr[id]) begin
          chk("unexpected_frame_len", id, len, 0);
        end else begin
          it = fifo[id][rd[id]];
          rd[id]++;
          nbits = 9 + ((par_of(id) != 0) ? 1 : 0) + stop_of(id);
          flen  = it.abort ? it.abort_len : nbits * N;
          chk("start_cycle", id, t0, it.start);
          chk("busy_len", id, len, flen);
          bad = -1;
          for (int k = 0; k < flen && k < len && k < 64; k++) begin
            bi = k / N;
            if (bi == 0) eb = 1'b0;
            else if (bi <= 8) eb = it.data[bi-1];
            else if (par_of(id) != 0 && bi == 9) eb = (par_of(id) == 1) ? it.even : ~it.even;
            else eb = 1'b1;
            if (wave[k] !== eb && bad < 0) bad = k;
          end
          chk("wave_first_bad_cycle", id, bad, -1);
          chk("end_tx_txdone", id, int'(tx_w[id]) * 2 + int'(done_w[id]), it.abort ? 2 : 3);
        end
      end else begin
        chk("idle_tx_txdone", id, int'(tx_w[id]) * 2 + int'(done_w[id]), 2);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  task automatic push(input int id, input logic [7:0] d, input logic ev);
    fifo[id][wr[id]] = '{data: d, even: ev, start: cyc + 1, abort: 1'b0, abort_len: 0};
    wr[id]++;
  endtask

  // Called at a negedge; txena is high for exactly one rising edge.
  task automatic send_one(input int id, input logic [7:0] d, input logic ev);
    txena[id] = 1'b1;
    txdata    = d;
    push(id, d, ev);
    @(negedge clk);
    txena  = 4'h0;
    txdata = 8'($urandom);
  endtask

  task automatic send_all(input logic [7:0] d, input logic ev);
    txena  = 4'hF;
    txdata = d;
    for (int id = 0; id < 4; id++) push(id, d, ev);
    @(negedge clk);
    txena  = 4'h0;
    txdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_w != 4'h0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 0, int'(t >= 300), 0);
    repeat (3) @(negedge clk);
  endtask

  // Vector table: byte and its hand-computed even parity bit.
  logic [7:0] vec_d[6]  = '{8'hA5, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h3C};
  logic       vec_ev[6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

  initial begin
    int t;
    @(negedge clk);
    for (int id = 0; id < 4; id++)
      chk("powerup", id, int'(tx_w[id]) * 4 + int'(busy_w[id]) * 2 + int'(done_w[id]), 4);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int id = 0; id < 4; id++)
      chk("reset_state", id, int'(tx_w[id]) * 4 + int'(busy_w[id]) * 2 + int'(done_w[id]), 4);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_all(vec_d[v], vec_ev[v]);
      wait_idle();
    end

    // txena and txdata changes mid-frame must be ignored.
    send_all(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    txena  = 4'hF;
    txdata = 8'h3C;
    @(negedge clk);
    txena  = 4'h0;
    txdata = 8'hFF;
    wait_idle();

    // Back-to-back: second request issued in the tx_done cycle.
    for (int id = 0; id < 4; id++) begin
      send_one(id, 8'hA5, 1'b0);
      t = 0;
      while (!done_w[id] && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("done_timeout", id, int'(t >= 300), 0);
      send_one(id, 8'h3C, 1'b0);
      wait_idle();
    end

    // Reset during data bit 3, with txena also asserted in the reset cycle.
    send_all(8'hA5, 1'b0);
    repeat (17) @(negedge clk);
    rst    = 1'b0;
    txena  = 4'hF;
    txdata = 8'h3C;
    for (int id = 0; id < 4; id++) begin
      fifo[id][wr[id]-1].abort     = 1'b1;
      fifo[id][wr[id]-1].abort_len = 18;
    end
    @(negedge clk);
    rst   = 1'b1;
    txena = 4'h0;
    for (int id = 0; id < 4; id++)
      chk("reset_mid", id, int'(tx_w[id]) * 4 + int'(busy_w[id]) * 2 + int'(done_w[id]), 4);
    @(negedge clk);
    for (int id = 0; id < 4; id++)
      chk("rst_over_txena", id, int'(busy_w[id]), 0);
    wait_idle();

    send_all(8'h5A, 1'b0);
    wait_idle();

    for (int id = 0; id < 4; id++)
      chk("pending_frames", id, wr[id] - rd[id], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
